cluster_link_formatter: RTL and testbench
=========================================

Name: cluster_link_formatter

Overview:
- Downstream of cluster_packer, in the clock4x domain.
- Each BX it takes the 8 packed 14-bit clusters, keeps only the valid ones, and buffers them in a multi-write FIFO.
- It drains the FIFO as a 16-bit word stream for the trigger link: 4 words per BX, one BX-marker slot plus three cluster slots.
- Drops on overflow are counted and flagged in-band.

Parameters:
- DEPTH, 16, FIFO entries; power of 2, minimum 8.
- AW, 4, log2(DEPTH).

Ports:
- clock4x  in  1  4x LHC clock, sole clock.
- global_reset_n  in  1  asynchronous reset, active low.
- bx_strobe  in  1  high for one clock4x cycle per BX; cluster0..7 are new and valid in that cycle.
- bc0  in  1  bunch-counter-zero; sampled only when bx_strobe=1.
- cluster0..cluster7  in  14 each  {size[13:11], addr[10:0]}.
- out_word  out  16  link word, registered.
- fifo_count  out  AW+1  current FIFO occupancy.
- overflow_cnt  out  16  dropped-cluster count, saturating.
- misalign  out  1  sticky: bx_strobe seen at phase!=3.

Behaviour:
- Cluster validity: addr < 11'd1536. Clusters with addr >= 1536, e.g. 0x7FF, are ignored. size is not checked.
- Phase: 2-bit counter, free-running mod 4. Reset value 3.
- Every edge with bx_strobe=1 forces phase to 0.
- If phase!=3 when bx_strobe arrives, set misalign. misalign is sticky until reset.
- Phase-0 edge (bx_strobe=1, or wrap 3->0 without strobe) registers the marker word: out_word <= {2'b10, ovf, 1'b0, bxn[11:0]}.
  - ovf=1 iff clusters are dropped at this same capture. ovf=0 on a no-strobe wrap.
- Phase 1..3 edges: if fifo_count>0, out_word <= {2'b01, head entry} and pop. Otherwise out_word <= 16'h0000 (idle).
- bxn counter, 12 bits:
  - Marker carries the current bxn, then bxn increments with natural wrap 4095->0.
  - If bc0=1 with bx_strobe, the marker carries 12'd0 and bxn becomes 1.
- Capture, only on bx_strobe edges:
  - Valid clusters are written in ascending index order (cluster0 first) at wr_ptr, wr_ptr+1, ... mod DEPTH.
  - n_valid is 0..8.
  - free = DEPTH - fifo_count.
  - If n_valid > free: write the first `free` valid clusters, drop the rest.
  - overflow_cnt += dropped, saturating at 16'hFFFF.
- Push and pop never coincide: pushes occur only at phase 0, pops only at phases 1-3.
- A cluster written at edge E is poppable at E+1. Minimum latency, strobe to cluster on out_word, is 2 edges: marker at E, cluster at E+1.
- FIFO order is strict FIFO across BXs. Pointers wrap mod DEPTH. fifo_count is the full occupancy, 0..DEPTH.
- Empty at a cluster slot emits idle. Full at capture drops all new clusters.
- Reset, asynchronous, while low:
  - out_word=0, fifo_count=0, pointers=0, overflow_cnt=0, misalign=0, bxn=0, phase=3.
  - Reset mid-stream discards FIFO contents.
  - First edge after release emits a marker, whether via strobe or via wrap.
- Sustained bandwidth: 3 clusters/BX out against up to 8 in; bursts are absorbed by DEPTH.

Test Plan:
- Reset release, no strobes:
  - out_word cycles marker(bxn=0), 0, 0, 0, marker(bxn=1), ...
  - fifo_count=0, misalign=0.
- Single strobe, cluster3=14'h0123, others 0x7FF:
  - marker 16'h8000 (bxn=0), then 16'h4123, then 16'h0000, 16'h0000.
- Strobe with all 8 valid, addr=index:
  - out order 0,1,2 in BX1; 3,4,5 in BX2; 6,7, idle in BX3.
  - fifo_count after capture = 8.
- Depth 16, three consecutive strobes with 8 valid each:
  - occupancy 8 -> 5 -> 13 -> 10.
  - Third capture writes 6, drops 2; marker ovf bit=1; overflow_cnt=2; fifo_count=16.
- bc0 with strobe while bxn=37:
  - marker bxn=0; next marker bxn=1.
- Strobe arriving at phase 1:
  - phase forced to 0, marker emitted, misalign=1.
  - misalign stays 1 until global_reset_n low.

Source files
------------

// File: rtl/cluster_link_formatter.sv
// Cluster link formatter: captures the valid packed clusters of each BX into a multi-write FIFO
// and drains them as a 4-word-per-BX link stream (one marker slot, three cluster slots).
module cluster_link_formatter #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clock4x,
  input  logic          global_reset_n,
  input  logic          bx_strobe,
  input  logic          bc0,
  input  logic [13:0]   cluster0,
  input  logic [13:0]   cluster1,
  input  logic [13:0]   cluster2,
  input  logic [13:0]   cluster3,
  input  logic [13:0]   cluster4,
  input  logic [13:0]   cluster5,
  input  logic [13:0]   cluster6,
  input  logic [13:0]   cluster7,
  output logic [15:0]   out_word,
  output logic [AW:0]   fifo_count,
  output logic [15:0]   overflow_cnt,
  output logic          misalign
);

  localparam logic [10:0] ADDR_LIMIT = 11'd1536;

  logic [13:0]   clus [8];
  logic [13:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [1:0]    phase;
  logic [11:0]   bxn;

  logic [7:0]    accept;
  logic [3:0]    rank [8];
  logic [3:0]    n_valid;
  logic [3:0]    n_push;
  logic [3:0]    n_drop;
  logic [AW:0]   free_slots;
  logic          marker_edge;
  logic          pop;
  logic [11:0]   marker_bxn;
  logic [16:0]   ovf_sum;

  assign clus[0] = cluster0;
  assign clus[1] = cluster1;
  assign clus[2] = cluster2;
  assign clus[3] = cluster3;
  assign clus[4] = cluster4;
  assign clus[5] = cluster5;
  assign clus[6] = cluster6;
  assign clus[7] = cluster7;

  // rank[i] is the FIFO offset cluster i lands at; valid clusters past the free space are dropped.
  always_comb begin
    n_valid    = '0;
    n_push     = '0;
    accept     = '0;
    free_slots = (AW+1)'(DEPTH) - fifo_count;
    for (int i = 0; i < 8; i++) begin
      rank[i] = n_valid;
      if (clus[i][10:0] < ADDR_LIMIT) begin
        if (32'(n_valid) < 32'(free_slots)) begin
          accept[i] = 1'b1;
          n_push    = n_push + 4'd1;
        end
        n_valid = n_valid + 4'd1;
      end
    end
    n_drop = n_valid - n_push;
  end

  assign marker_edge = bx_strobe || (phase == 2'd3);
  assign pop         = !marker_edge && (fifo_count != '0);
  assign marker_bxn  = (bx_strobe && bc0) ? 12'd0 : bxn;
  assign ovf_sum     = {1'b0, overflow_cnt} + 17'(n_drop);

  always_ff @(posedge clock4x or negedge global_reset_n) begin
    if (!global_reset_n) begin
      phase        <= 2'd3;
      bxn          <= '0;
      out_word     <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count   <= '0;
      overflow_cnt <= '0;
      misalign     <= 1'b0;
    end else begin
      phase <= bx_strobe ? 2'd0 : phase + 2'd1;
      if (bx_strobe && phase != 2'd3) misalign <= 1'b1;

      if (marker_edge) begin
        out_word <= {2'b10, (bx_strobe && n_drop != 4'd0), 1'b0, marker_bxn};
        bxn      <= marker_bxn + 12'd1;
      end else if (pop) begin
        out_word   <= {2'b01, mem[rd_ptr]};
        rd_ptr     <= rd_ptr + AW'(1);
        fifo_count <= fifo_count - (AW+1)'(1);
      end else begin
        out_word <= '0;
      end

      // Pushes only happen on strobe edges, which are always marker edges, so never with a pop.
      if (bx_strobe) begin
        wr_ptr       <= wr_ptr + AW'(n_push);
        fifo_count   <= fifo_count + (AW+1)'(n_push);
        overflow_cnt <= ovf_sum[16] ? 16'hFFFF : ovf_sum[15:0];
      end
    end
  end

  always_ff @(posedge clock4x) begin
    if (bx_strobe) begin
      for (int i = 0; i < 8; i++) begin
        if (accept[i]) mem[wr_ptr + AW'(rank[i])] <= clus[i];
      end
    end
  end

endmodule

// File: tb/tb_cluster_link_formatter.sv
// Bench for cluster_link_formatter: directed scenarios plus random BX traffic against a
// queue-based reference model of the link stream.
module tb_cluster_link_formatter;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk;
  logic          global_reset_n;
  logic          bx_strobe;
  logic          bc0;
  logic [13:0]   cl [8];
  logic [15:0]   out_word;
  logic [AW:0]   fifo_count;
  logic [15:0]   overflow_cnt;
  logic          misalign;

  cluster_link_formatter #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clock4x        (clk),
    .global_reset_n (global_reset_n),
    .bx_strobe      (bx_strobe),
    .bc0            (bc0),
    .cluster0       (cl[0]),
    .cluster1       (cl[1]),
    .cluster2       (cl[2]),
    .cluster3       (cl[3]),
    .cluster4       (cl[4]),
    .cluster5       (cl[5]),
    .cluster6       (cl[6]),
    .cluster7       (cl[7]),
    .out_word       (out_word),
    .fifo_count     (fifo_count),
    .overflow_cnt   (overflow_cnt),
    .misalign       (misalign)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  logic [13:0] mq[$];
  int          m_phase;
  int          m_bxn;
  int          m_ovf;
  logic        m_mis;
  logic [15:0] m_out;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_phase = 3;
    m_bxn   = 0;
    m_ovf   = 0;
    m_mis   = 1'b0;
    m_out   = 16'h0000;
  endtask

  // One clock4x edge of the link: marker slot on strobe or wrap, otherwise a cluster slot.
  task automatic model_edge();
    int drop;
    int b;
    drop = 0;
    if (bx_strobe || m_phase == 3) begin
      if (bx_strobe && m_phase != 3) m_mis = 1'b1;
      b = (bx_strobe && bc0) ? 0 : m_bxn;
      m_bxn = (b + 1) % 4096;
      if (bx_strobe) begin
        for (int i = 0; i < 8; i++) begin
          if (cl[i][10:0] < 11'd1536) begin
            if (mq.size() < DEPTH) mq.push_back(cl[i]);
            else drop++;
          end
        end
      end
      m_ovf   = (m_ovf + drop > 65535) ? 65535 : m_ovf + drop;
      m_out   = {2'b10, (drop > 0), 1'b0, 12'(b)};
      m_phase = 0;
    end else begin
      m_phase = m_phase + 1;
      if (mq.size() > 0) m_out = {2'b01, mq.pop_front()};
      else m_out = 16'h0000;
    end
  endtask

  // driver tasks
  task automatic idle_inputs();
    bx_strobe = 1'b0;
    bc0       = 1'b0;
    for (int i = 0; i < 8; i++) cl[i] = 14'h07FF;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_val("out_word", 32'(out_word), 32'(m_out));
    check_val("fifo_count", 32'(fifo_count), mq.size());
    check_val("overflow_cnt", 32'(overflow_cnt), m_ovf);
    check_val("misalign", 32'(misalign), 32'(m_mis));
  endtask

  task automatic strobe_tick(input logic b);
    bx_strobe = 1'b1;
    bc0       = b;
    tick();
    idle_inputs();
  endtask

  task automatic reset_dut();
    idle_inputs();
    global_reset_n = 1'b0;
    #2;
    model_reset();
    check_val("rst_out_word", 32'(out_word), 0);
    check_val("rst_fifo_count", 32'(fifo_count), 0);
    check_val("rst_overflow_cnt", 32'(overflow_cnt), 0);
    check_val("rst_misalign", 32'(misalign), 0);
    @(negedge clk);
    global_reset_n = 1'b1;
  endtask

  initial begin
    idle_inputs();
    global_reset_n = 1'b0;

    // Reset release with no strobes: marker, 3 idles, next marker.
    reset_dut();
    tick();
    check_val("free_marker0", 32'(out_word), 32'h8000);
    for (int k = 0; k < 3; k++) tick();
    check_val("free_idle", 32'(out_word), 32'h0000);
    tick();
    check_val("free_marker1", 32'(out_word), 32'h8001);
    for (int k = 0; k < 3; k++) tick();

    // Single valid cluster3.
    reset_dut();
    cl[3] = 14'h0123;
    strobe_tick(1'b0);
    check_val("single_marker", 32'(out_word), 32'h8000);
    tick();
    check_val("single_cluster", 32'(out_word), 32'h4123);
    tick();
    check_val("single_idle", 32'(out_word), 32'h0000);
    tick();

    // All eight valid, addr = index.
    reset_dut();
    for (int i = 0; i < 8; i++) cl[i] = 14'(i);
    strobe_tick(1'b0);
    check_val("all8_count", 32'(fifo_count), 8);
    for (int k = 0; k < 11; k++) tick();
    check_val("all8_tail_idle", 32'(out_word), 32'h0000);

    // Three back-to-back full captures overflow a 16-deep FIFO by 2.
    reset_dut();
    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < 8; i++) cl[i] = {3'(s), 11'(i + 8 * s)};
      strobe_tick(1'b0);
      if (s < 2) begin
        check_val("burst_cap_count", 32'(fifo_count), (s == 0) ? 8 : 13);
        for (int k = 0; k < 3; k++) tick();
        check_val("burst_drain_count", 32'(fifo_count), (s == 0) ? 5 : 10);
      end
    end
    check_val("burst_ovf_bit", 32'(out_word[13]), 1);
    check_val("burst_ovf_cnt", 32'(overflow_cnt), 2);
    check_val("burst_full", 32'(fifo_count), 16);
    for (int k = 0; k < 24; k++) tick();

    // bc0 while bxn = 37.
    reset_dut();
    for (int k = 0; k < 37 * 4; k++) tick();
    strobe_tick(1'b1);
    check_val("bc0_marker", 32'(out_word), 32'h8000);
    for (int k = 0; k < 4; k++) tick();
    check_val("bc0_next_marker", 32'(out_word), 32'h8001);

    // Strobe arriving at phase 1.
    reset_dut();
    tick();
    tick();
    cl[0] = 14'h0055;
    strobe_tick(1'b0);
    check_val("mis_flag", 32'(misalign), 1);
    check_val("mis_marker", 32'(out_word[15:14]), 32'h2);
    for (int k = 0; k < 10; k++) tick();
    check_val("mis_sticky", 32'(misalign), 1);
    reset_dut();
    check_val("mis_cleared", 32'(misalign), 0);

    // Random traffic, mostly aligned strobes, with one reset mid-stream.
    for (int c = 0; c < 2000; c++) begin
      if (c == 1000) reset_dut();
      if ((m_phase == 3 && $urandom_range(0, 9) < 8) || $urandom_range(0, 99) < 3) begin
        for (int i = 0; i < 8; i++) begin
          cl[i] = {3'($urandom_range(0, 7)),
                   ($urandom_range(0, 9) < 6) ? 11'($urandom_range(0, 1535))
                                               : 11'($urandom_range(1536, 2047))};
        end
        bx_strobe = 1'b1;
        bc0       = ($urandom_range(0, 9) == 0);
      end else begin
        idle_inputs();
      end
      tick();
    end
    idle_inputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
